// File: rtl/mul54_final_add_pipe_if.sv
// Handshake and data bundle for the final-add pipeline.
// carry_out exists only when MUL54_FINAL_ADD_CARRY_OUT_EN is defined.
interface mul54_final_add_pipe_if #(
   parameter int unsigned radix = 54
);
   logic                 in_valid;
   logic                 in_ready;
   logic [radix*2-1:0]   res_0;
   logic [radix*2-1:0]   res_1;
   logic                 out_valid;
   logic                 out_ready;
   logic [radix*2-1:0]   sum;
`ifdef MUL54_FINAL_ADD_CARRY_OUT_EN
   logic                 carry_out;

   modport master (
      output in_valid, res_0, res_1, out_ready,
      input  in_ready, out_valid, sum, carry_out
   );
   modport slave (
      input  in_valid, res_0, res_1, out_ready,
      output in_ready, out_valid, sum, carry_out
   );
`else
   modport master (
      output in_valid, res_0, res_1, out_ready,
      input  in_ready, out_valid, sum
   );
   modport slave (
      input  in_valid, res_0, res_1, out_ready,
      output in_ready, out_valid, sum
   );
`endif
endinterface

// File: rtl/mul54_final_add_pipe.sv
// Two-stage carry-split adder resolving res_0 + res_1 into a 2*radix-bit sum.
// Define MUL54_FINAL_ADD_CARRY_OUT_EN to expose the top carry as carry_out.
module mul54_final_add_pipe #(
   parameter int unsigned radix = 54,
   parameter int unsigned LO_W  = radix
) (
   input logic                   clk,
   input logic                   rst_n,
   mul54_final_add_pipe_if.slave bus
);
   localparam int unsigned W    = radix * 2;
   localparam int unsigned HI_W = W - LO_W;
`ifdef MUL54_FINAL_ADD_CARRY_OUT_EN
   localparam int unsigned HS_W = HI_W + 1;
`else
   localparam int unsigned HS_W = HI_W;
`endif

   logic            r_s1_valid;
   logic            r_s2_valid;
   logic            r_s1_c;
   logic [LO_W-1:0] r_s1_lo;
   logic [HI_W-1:0] r_s1_h0;
   logic [HI_W-1:0] r_s1_h1;
   logic [W-1:0]    r_sum;
`ifdef MUL54_FINAL_ADD_CARRY_OUT_EN
   logic            r_carry;
`endif

   logic            w_s2_free;
   logic            w_s1_adv;
   logic            w_in_ready;
   logic            w_in_xfer;
   logic            w_out_pop;
   logic [LO_W:0]   w_lo;
   logic [HS_W-1:0] w_hi;

   assign w_s2_free  = !r_s2_valid || bus.out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_free;
   assign w_in_ready = !r_s1_valid || w_s2_free;
   assign w_in_xfer  = bus.in_valid && w_in_ready;
   assign w_out_pop  = r_s2_valid && bus.out_ready;

   assign w_lo = {1'b0, bus.res_0[LO_W-1:0]} + {1'b0, bus.res_1[LO_W-1:0]};
   // Without the carry-out feature the high add is kept at HI_W bits so no dead MSB exists.
   assign w_hi = HS_W'(r_s1_h0) + HS_W'(r_s1_h1) + HS_W'(r_s1_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_c     <= 1'b0;
         r_s1_lo    <= '0;
         r_s1_h0    <= '0;
         r_s1_h1    <= '0;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_c     <= w_lo[LO_W];
         r_s1_lo    <= w_lo[LO_W-1:0];
         r_s1_h0    <= bus.res_0[W-1:LO_W];
         r_s1_h1    <= bus.res_1[W-1:LO_W];
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_sum      <= '0;
`ifdef MUL54_FINAL_ADD_CARRY_OUT_EN
         r_carry    <= 1'b0;
`endif
      end else if (w_s1_adv) begin
         r_s2_valid <= 1'b1;
         r_sum      <= {w_hi[HI_W-1:0], r_s1_lo};
`ifdef MUL54_FINAL_ADD_CARRY_OUT_EN
         r_carry    <= w_hi[HI_W];
`endif
      end else if (w_out_pop) begin
         r_s2_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.sum       = r_sum;
`ifdef MUL54_FINAL_ADD_CARRY_OUT_EN
   assign bus.carry_out = r_carry;
`endif

endmodule

// File: tb/tb_mul54_final_add_pipe.sv
// Scoreboard bench for mul54_final_add_pipe: directed vectors push expectations,
// a negedge monitor pops and compares every accepted output.
module tb_mul54_final_add_pipe;
   logic clk = 1'b0;
   logic rst_n;
   int unsigned cyc = 0;
   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [107:0] s;
      logic         c;
      logic         lat;
      int unsigned  cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul54_final_add_pipe_if #(.radix(54)) bus ();

   mul54_final_add_pipe #(.radix(54), .LO_W(54)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [107:0] act, input logic [107:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got sum %0h, required no output", bus.sum);
         end else begin
            mon_e = q.pop_front();
            chk("sum", bus.sum, mon_e.s);
`ifdef MUL54_FINAL_ADD_CARRY_OUT_EN
            chk("carry_out", {107'd0, bus.carry_out}, {107'd0, mon_e.c});
`endif
            if (mon_e.lat) chk("latency_cycle", 108'(cyc), 108'(mon_e.cyc));
         end
      end
   end

   task automatic send(input logic [107:0] a, input logic [107:0] b,
                       input logic [107:0] s, input logic c, input logic lat);
      exp_t e;
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.res_0    = a;
      bus.res_1    = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready 0, required 1");
         bus.in_valid = 1'b0;
         return;
      end
      e.s   = s;
      e.c   = c;
      e.lat = lat;
      e.cyc = cyc + 2;
      q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL drain_timeout: %0d outputs pending, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_out_valid", {107'd0, bus.out_valid}, 108'd0);
         chk("idle_in_ready", {107'd0, bus.in_ready}, 108'd1);
         chk("idle_sum", bus.sum, 108'd0);
      end
   endtask

   logic [107:0] sa[8];
   logic [107:0] sb[8];
   logic [107:0] ss[8];
   logic         sc[8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sa[0] = 108'd3;                 sb[0] = 108'd4;                 ss[0] = 108'd7;                 sc[0] = 1'b0;
      sa[1] = 108'd1 << 54;           sb[1] = 108'd1 << 54;           ss[1] = 108'd1 << 55;           sc[1] = 1'b0;
      sa[2] = ~108'd0;                sb[2] = 108'd1;                 ss[2] = 108'd0;                 sc[2] = 1'b1;
      sa[3] = 108'd0;                 sb[3] = 108'd0;                 ss[3] = 108'd0;                 sc[3] = 1'b0;
      sa[4] = 108'd1 << 53;           sb[4] = 108'd1 << 53;           ss[4] = 108'd1 << 54;           sc[4] = 1'b0;
      sa[5] = 108'd1 << 107;          sb[5] = 108'd1 << 107;          ss[5] = 108'd0;                 sc[5] = 1'b1;
      sa[6] = (108'd1 << 107) - 1;    sb[6] = 108'd1;                 ss[6] = 108'd1 << 107;          sc[6] = 1'b0;
      sa[7] = 108'd123456789;         sb[7] = 108'd987654321;         ss[7] = 108'd1111111110;        sc[7] = 1'b0;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.res_0     = '0;
      bus.res_1     = '0;
      bus.out_ready = 1'b1;

      // Reset then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {107'd0, bus.out_valid}, 108'd0);
      chk("rst_sum", bus.sum, 108'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_chk(5);

      // Carry crossing the low slice, then full-width wrap
      @(posedge clk);
      #1;
      send((108'd1 << 54) - 1, 108'd1, 108'd1 << 54, 1'b0, 1'b1);
      send(~108'd0, 108'd2, 108'd1, 1'b1, 1'b1);
      drain();

      // Back-to-back streaming
      for (int i = 0; i < 8; i++) send(sa[i], sb[i], ss[i], sc[i], 1'b1);
      drain();

      // Backpressure with both stages full
      send(108'd5, 108'd7, 108'd12, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      send(108'd100, 108'd200, 108'd300, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {107'd0, bus.in_ready}, 108'd0);
         chk("stall_out_valid", {107'd0, bus.out_valid}, 108'd1);
         chk("stall_sum", bus.sum, 108'd12);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
      @(negedge clk);
      chk("after_drain_out_valid", {107'd0, bus.out_valid}, 108'd0);

      // Reset mid-flight drops both in-flight results
      @(posedge clk);
      #1;
      send(108'd11, 108'd22, 108'd33, 1'b0, 1'b0);
      send(108'd44, 108'd55, 108'd99, 1'b0, 1'b0);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_out_valid", {107'd0, bus.out_valid}, 108'd0);
      chk("midrst_sum", bus.sum, 108'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_chk(5);

      // Recovery after reset
      @(posedge clk);
      #1;
      send(108'd7, 108'd8, 108'd15, 1'b0, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
